// File: rtl/mac_seq_ctrl_pkg.sv
// Shared math-unit definitions: sequencer state encoding and array bus widths.
package mac_seq_ctrl_pkg;

  localparam int OUT_SEL_W = 6;
  localparam int OPER_W    = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mac_seq_ctrl.sv
// Runs one dot-product job on the MAC array: clear, gated accumulate of N pairs,
// settle wait, then presents the MAC0 lane result on a valid/ready handshake.
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int TAP_W   = 8,
  parameter int RES_LAT = 1
) (
  input  logic                 MAC_ACC_CLK,
  input  logic                 acc_ff_rstn,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [TAP_W-1:0]     CFG_NUM_TAPS,
  input  logic                 CFG_RND,
  input  logic                 CFG_SAT,
  input  logic                 CFG_TC,
  input  logic [OUT_SEL_W-1:0] CFG_OUT_SEL,
  input  logic                 OPER_VALID,
  output logic                 OPER_READY,
  input  logic [OPER_W-1:0]    OPER_DATA,
  input  logic [OPER_W-1:0]    COEF_DATA,
  output logic [OPER_W-1:0]    MAC_OPER_DATA,
  output logic [OPER_W-1:0]    MAC_COEF_DATA,
  output logic                 EFPGA_MATHB_CLK_EN,
  output logic                 MAC_ACC_CLEAR,
  output logic                 MAC_ACC_RND,
  output logic                 MAC_ACC_SAT,
  output logic                 MAC_TC,
  output logic [OUT_SEL_W-1:0] MAC_OUT_SEL,
  input  logic [OPER_W-1:0]    MAC0_OUT,
  output logic [OPER_W-1:0]    RES_DATA,
  output logic                 RES_VALID,
  input  logic                 RES_READY,
  output logic                 BUSY
);

  localparam int LAT_W = (RES_LAT < 1) ? 1 : $clog2(RES_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RES_LAT);

  state_t           state;
  logic [TAP_W-1:0] tap_cnt;
  logic [TAP_W-1:0] last_tap;
  logic [LAT_W-1:0] lat_cnt;
  logic             oper_hs;

  assign oper_hs = OPER_VALID & OPER_READY;

  always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      state              <= ST_IDLE;
      tap_cnt            <= '0;
      last_tap           <= '0;
      lat_cnt            <= '0;
      OPER_READY         <= 1'b0;
      MAC_OPER_DATA      <= '0;
      MAC_COEF_DATA      <= '0;
      EFPGA_MATHB_CLK_EN <= 1'b0;
      MAC_ACC_CLEAR      <= 1'b0;
      MAC_ACC_RND        <= 1'b0;
      MAC_ACC_SAT        <= 1'b0;
      MAC_TC             <= 1'b0;
      MAC_OUT_SEL        <= '0;
      RES_DATA           <= '0;
      RES_VALID          <= 1'b0;
      BUSY               <= 1'b0;
    end else if (ABORT) begin
      // Abort lands in the same all-quiet state as reset.
      state              <= ST_IDLE;
      tap_cnt            <= '0;
      lat_cnt            <= '0;
      OPER_READY         <= 1'b0;
      MAC_OPER_DATA      <= '0;
      MAC_COEF_DATA      <= '0;
      EFPGA_MATHB_CLK_EN <= 1'b0;
      MAC_ACC_CLEAR      <= 1'b0;
      MAC_ACC_RND        <= 1'b0;
      MAC_ACC_SAT        <= 1'b0;
      MAC_TC             <= 1'b0;
      MAC_OUT_SEL        <= '0;
      RES_DATA           <= '0;
      RES_VALID          <= 1'b0;
      BUSY               <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            last_tap           <= (CFG_NUM_TAPS == '0) ? '0 : CFG_NUM_TAPS - TAP_W'(1);
            tap_cnt            <= '0;
            MAC_ACC_RND        <= CFG_RND;
            MAC_ACC_SAT        <= CFG_SAT;
            MAC_TC             <= CFG_TC;
            MAC_OUT_SEL        <= CFG_OUT_SEL;
            MAC_ACC_CLEAR      <= 1'b1;
            EFPGA_MATHB_CLK_EN <= 1'b1;
            MAC_OPER_DATA      <= '0;
            MAC_COEF_DATA      <= '0;
            BUSY               <= 1'b1;
            state              <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          MAC_ACC_CLEAR      <= 1'b0;
          EFPGA_MATHB_CLK_EN <= 1'b0;
          OPER_READY         <= 1'b1;
          state              <= ST_RUN;
        end
        ST_RUN: begin
          // Enable follows the handshake by one cycle so idle cycles never accumulate.
          EFPGA_MATHB_CLK_EN <= oper_hs;
          if (oper_hs) begin
            MAC_OPER_DATA <= OPER_DATA;
            MAC_COEF_DATA <= COEF_DATA;
            if (tap_cnt == last_tap) begin
              OPER_READY <= 1'b0;
              tap_cnt    <= '0;
              lat_cnt    <= '0;
              state      <= ST_DRAIN;
            end else begin
              tap_cnt <= tap_cnt + TAP_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          EFPGA_MATHB_CLK_EN <= 1'b0;
          if (lat_cnt == LAT_LAST) begin
            RES_DATA  <= MAC0_OUT;
            RES_VALID <= 1'b1;
            state     <= ST_DONE;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        ST_DONE: begin
          if (RES_READY) begin
            RES_VALID <= 1'b0;
            BUSY      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural accumulate-only MAC array stub.
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        START, ABORT;
  logic [7:0]  CFG_NUM_TAPS;
  logic        CFG_RND, CFG_SAT, CFG_TC;
  logic [5:0]  CFG_OUT_SEL;
  logic        OPER_VALID, OPER_READY;
  logic [31:0] OPER_DATA, COEF_DATA, MAC_OPER_DATA, MAC_COEF_DATA;
  logic        EN, MAC_ACC_CLEAR, MAC_ACC_RND, MAC_ACC_SAT, MAC_TC;
  logic [5:0]  MAC_OUT_SEL;
  logic [31:0] MAC0_OUT, RES_DATA, acc;
  logic        RES_VALID, RES_READY, BUSY;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int en_cnt = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  mac_seq_ctrl #(.TAP_W(8), .RES_LAT(1)) dut (
    .MAC_ACC_CLK(clk), .acc_ff_rstn(rst_n), .START(START), .ABORT(ABORT),
    .CFG_NUM_TAPS(CFG_NUM_TAPS), .CFG_RND(CFG_RND), .CFG_SAT(CFG_SAT), .CFG_TC(CFG_TC),
    .CFG_OUT_SEL(CFG_OUT_SEL), .OPER_VALID(OPER_VALID), .OPER_READY(OPER_READY),
    .OPER_DATA(OPER_DATA), .COEF_DATA(COEF_DATA), .MAC_OPER_DATA(MAC_OPER_DATA),
    .MAC_COEF_DATA(MAC_COEF_DATA), .EFPGA_MATHB_CLK_EN(EN), .MAC_ACC_CLEAR(MAC_ACC_CLEAR),
    .MAC_ACC_RND(MAC_ACC_RND), .MAC_ACC_SAT(MAC_ACC_SAT), .MAC_TC(MAC_TC),
    .MAC_OUT_SEL(MAC_OUT_SEL), .MAC0_OUT(MAC0_OUT), .RES_DATA(RES_DATA),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .BUSY(BUSY)
  );

  // Array stub: accumulates on enabled edges, combinational lane output.
  always @(posedge clk) if (EN) acc <= MAC_ACC_CLEAR ? 32'd0 : acc + MAC_OPER_DATA * MAC_COEF_DATA;
  assign MAC0_OUT = acc;

  always @(negedge clk) begin
    if (EN && !MAC_ACC_CLEAR) en_cnt++;
    if (OPER_VALID && OPER_READY) hs_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] taps, input logic rnd, input logic sat,
                           input logic tc, input logic [5:0] sel);
    CFG_NUM_TAPS = taps; CFG_RND = rnd; CFG_SAT = sat; CFG_TC = tc; CFG_OUT_SEL = sel;
    START = 1'b1;
    tick;
    START = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    OPER_VALID = 1'b1; OPER_DATA = a; COEF_DATA = b;
    tick;
  endtask

  task automatic pop_result;
    RES_READY = 1'b1;
    tick;
    RES_READY = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    START = 0; ABORT = 0; CFG_NUM_TAPS = 0; CFG_RND = 0; CFG_SAT = 0; CFG_TC = 0; CFG_OUT_SEL = 0;
    OPER_VALID = 0; OPER_DATA = 0; COEF_DATA = 0; RES_READY = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++; if (OPER_READY !== 1'b0) $display("FAIL rst_ready act=%b exp=0", OPER_READY); else pass_cnt++;
    chk_cnt++; if (EN !== 1'b0) $display("FAIL rst_en act=%b exp=0", EN); else pass_cnt++;
    chk_cnt++; if (BUSY !== 1'b0) $display("FAIL rst_busy act=%b exp=0", BUSY); else pass_cnt++;
    chk_cnt++; if (RES_VALID !== 1'b0) $display("FAIL rst_res_valid act=%b exp=0", RES_VALID); else pass_cnt++;
    chk_cnt++; if (RES_DATA !== 32'd0) $display("FAIL rst_res_data act=%0h exp=0", RES_DATA); else pass_cnt++;
    chk_cnt++; if (MAC_OUT_SEL !== 6'd0) $display("FAIL rst_out_sel act=%0h exp=0", MAC_OUT_SEL); else pass_cnt++;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_stream;
    start_job(8'd4, 1'b1, 1'b0, 1'b1, 6'h2A);
    en_cnt = 0;
    chk_cnt++; if (MAC_ACC_CLEAR !== 1'b1) $display("FAIL stream_clear act=%b exp=1", MAC_ACC_CLEAR); else pass_cnt++;
    chk_cnt++; if (EN !== 1'b1) $display("FAIL stream_clear_en act=%b exp=1", EN); else pass_cnt++;
    chk_cnt++; if (OPER_READY !== 1'b0) $display("FAIL stream_clear_ready act=%b exp=0", OPER_READY); else pass_cnt++;
    chk_cnt++; if (MAC_OUT_SEL !== 6'h2A) $display("FAIL stream_out_sel act=%0h exp=2a", MAC_OUT_SEL); else pass_cnt++;
    chk_cnt++; if ({MAC_ACC_RND, MAC_ACC_SAT, MAC_TC} !== 3'b101) $display("FAIL stream_cfg act=%b exp=101", {MAC_ACC_RND, MAC_ACC_SAT, MAC_TC}); else pass_cnt++;
    tick;
    chk_cnt++; if (OPER_READY !== 1'b1) $display("FAIL stream_ready act=%b exp=1", OPER_READY); else pass_cnt++;
    chk_cnt++; if (EN !== 1'b0) $display("FAIL stream_run_en act=%b exp=0", EN); else pass_cnt++;
    for (int i = 1; i <= 4; i++) send(32'(i), 32'd1);
    OPER_VALID = 1'b0;
    chk_cnt++; if (OPER_READY !== 1'b0) $display("FAIL stream_ready_drop act=%b exp=0", OPER_READY); else pass_cnt++;
    chk_cnt++; if (EN !== 1'b1) $display("FAIL stream_last_en act=%b exp=1", EN); else pass_cnt++;
    chk_cnt++; if (MAC_OPER_DATA !== 32'd4) $display("FAIL stream_oper act=%0d exp=4", MAC_OPER_DATA); else pass_cnt++;
    tick;
    chk_cnt++; if (RES_VALID !== 1'b0) $display("FAIL stream_early_valid act=%b exp=0", RES_VALID); else pass_cnt++;
    tick;
    chk_cnt++; if (RES_VALID !== 1'b1) $display("FAIL stream_valid act=%b exp=1", RES_VALID); else pass_cnt++;
    chk_cnt++; if (RES_DATA !== 32'd10) $display("FAIL stream_data act=%0d exp=10", RES_DATA); else pass_cnt++;
    chk_cnt++; if (en_cnt !== 4) $display("FAIL stream_en_cycles act=%0d exp=4", en_cnt); else pass_cnt++;
    pop_result;
    chk_cnt++; if (RES_VALID !== 1'b0) $display("FAIL stream_pop_valid act=%b exp=0", RES_VALID); else pass_cnt++;
    chk_cnt++; if (BUSY !== 1'b0) $display("FAIL stream_idle_busy act=%b exp=0", BUSY); else pass_cnt++;
    chk_cnt++; if (MAC_OUT_SEL !== 6'h2A) $display("FAIL stream_idle_sel act=%0h exp=2a", MAC_OUT_SEL); else pass_cnt++;
  endtask

  task automatic test_bubbles;
    logic [31:0] op [3] = '{32'd5, 32'hFFFF_FFFF, 32'd7};
    logic [31:0] cf [3] = '{32'd2, 32'hFFFF_FFFF, 32'd0};
    start_job(8'd3, 1'b0, 1'b0, 1'b1, 6'h01);
    tick;
    for (int i = 0; i < 3; i++) begin
      send(op[i], cf[i]);
      OPER_VALID = 1'b0;
      chk_cnt++; if (EN !== 1'b1) $display("FAIL bubble_en_after_hs%0d act=%b exp=1", i, EN); else pass_cnt++;
      if (i < 2) begin
        tick;
        chk_cnt++; if (EN !== 1'b0) $display("FAIL bubble_en_gap%0d act=%b exp=0", i, EN); else pass_cnt++;
      end
    end
    chk_cnt++; if (OPER_READY !== 1'b0) $display("FAIL bubble_ready act=%b exp=0", OPER_READY); else pass_cnt++;
    tick;
    tick;
    chk_cnt++; if (RES_VALID !== 1'b1) $display("FAIL bubble_valid act=%b exp=1", RES_VALID); else pass_cnt++;
    chk_cnt++; if (RES_DATA !== 32'd11) $display("FAIL bubble_data act=%0d exp=11", RES_DATA); else pass_cnt++;
    chk_cnt++; if (MAC_TC !== 1'b1) $display("FAIL bubble_tc act=%b exp=1", MAC_TC); else pass_cnt++;
    pop_result;
  endtask

  task automatic test_zero_taps;
    start_job(8'd0, 1'b0, 1'b0, 1'b0, 6'h00);
    tick;
    hs_cnt = 0;
    send(32'd9, 32'd9);
    chk_cnt++; if (OPER_READY !== 1'b0) $display("FAIL zero_ready act=%b exp=0", OPER_READY); else pass_cnt++;
    chk_cnt++; if (EN !== 1'b1) $display("FAIL zero_en act=%b exp=1", EN); else pass_cnt++;
    tick;
    tick;
    OPER_VALID = 1'b0;
    chk_cnt++; if (RES_VALID !== 1'b1) $display("FAIL zero_valid act=%b exp=1", RES_VALID); else pass_cnt++;
    chk_cnt++; if (RES_DATA !== 32'd81) $display("FAIL zero_data act=%0d exp=81", RES_DATA); else pass_cnt++;
    chk_cnt++; if (hs_cnt !== 1) $display("FAIL zero_handshakes act=%0d exp=1", hs_cnt); else pass_cnt++;
    pop_result;
  endtask

  task automatic test_back_to_back;
    start_job(8'd1, 1'b0, 1'b0, 1'b0, 6'h05);
    tick;
    send(32'd6, 32'd7);
    OPER_VALID = 1'b0;
    tick;
    tick;
    for (int i = 0; i < 10; i++) begin
      START = 1'b1;
      chk_cnt++; if (RES_VALID !== 1'b1) $display("FAIL hold_valid%0d act=%b exp=1", i, RES_VALID); else pass_cnt++;
      chk_cnt++; if (RES_DATA !== 32'd42) $display("FAIL hold_data%0d act=%0d exp=42", i, RES_DATA); else pass_cnt++;
      chk_cnt++; if (BUSY !== 1'b1) $display("FAIL hold_busy%0d act=%b exp=1", i, BUSY); else pass_cnt++;
      chk_cnt++; if (MAC_ACC_CLEAR !== 1'b0) $display("FAIL hold_start_ignored%0d act=%b exp=0", i, MAC_ACC_CLEAR); else pass_cnt++;
      tick;
    end
    START = 1'b0;
    pop_result;
    chk_cnt++; if (BUSY !== 1'b0) $display("FAIL b2b_idle act=%b exp=0", BUSY); else pass_cnt++;
    start_job(8'd1, 1'b0, 1'b0, 1'b0, 6'h05);
    chk_cnt++; if (MAC_ACC_CLEAR !== 1'b1) $display("FAIL b2b_restart act=%b exp=1", MAC_ACC_CLEAR); else pass_cnt++;
    ABORT = 1'b1;
    tick;
    ABORT = 1'b0;
  endtask

  task automatic test_abort;
    start_job(8'd4, 1'b1, 1'b1, 1'b1, 6'h3F);
    tick;
    send(32'd5, 32'd5);
    send(32'd2, 32'd2);
    ABORT = 1'b1; OPER_DATA = 32'd3; COEF_DATA = 32'd3; RES_READY = 1'b1;
    tick;
    ABORT = 1'b0; OPER_VALID = 1'b0; RES_READY = 1'b0;
    chk_cnt++; if (OPER_READY !== 1'b0) $display("FAIL abort_ready act=%b exp=0", OPER_READY); else pass_cnt++;
    chk_cnt++; if (EN !== 1'b0) $display("FAIL abort_en act=%b exp=0", EN); else pass_cnt++;
    chk_cnt++; if (BUSY !== 1'b0) $display("FAIL abort_busy act=%b exp=0", BUSY); else pass_cnt++;
    chk_cnt++; if (MAC_OPER_DATA !== 32'd0) $display("FAIL abort_oper act=%0d exp=0", MAC_OPER_DATA); else pass_cnt++;
    chk_cnt++; if (MAC_OUT_SEL !== 6'd0) $display("FAIL abort_sel act=%0h exp=0", MAC_OUT_SEL); else pass_cnt++;
    chk_cnt++; if ({MAC_ACC_RND, MAC_ACC_SAT, MAC_TC, MAC_ACC_CLEAR, RES_VALID} !== 5'd0) $display("FAIL abort_ctrl act=%b exp=00000", {MAC_ACC_RND, MAC_ACC_SAT, MAC_TC, MAC_ACC_CLEAR, RES_VALID}); else pass_cnt++;
    start_job(8'd2, 1'b0, 1'b0, 1'b0, 6'h00);
    tick;
    send(32'd3, 32'd3);
    send(32'd1, 32'd1);
    OPER_VALID = 1'b0;
    tick;
    tick;
    chk_cnt++; if (RES_VALID !== 1'b1) $display("FAIL abort_next_valid act=%b exp=1", RES_VALID); else pass_cnt++;
    chk_cnt++; if (RES_DATA !== 32'd10) $display("FAIL abort_next_data act=%0d exp=10", RES_DATA); else pass_cnt++;
    pop_result;
  endtask

  task automatic test_reset_mid;
    start_job(8'd3, 1'b0, 1'b1, 1'b0, 6'h11);
    tick;
    send(32'd8, 32'd8);
    OPER_VALID = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (OPER_READY !== 1'b0) $display("FAIL rstmid_ready act=%b exp=0", OPER_READY); else pass_cnt++;
    chk_cnt++; if (EN !== 1'b0) $display("FAIL rstmid_en act=%b exp=0", EN); else pass_cnt++;
    chk_cnt++; if (BUSY !== 1'b0) $display("FAIL rstmid_busy act=%b exp=0", BUSY); else pass_cnt++;
    chk_cnt++; if (MAC_OPER_DATA !== 32'd0) $display("FAIL rstmid_oper act=%0d exp=0", MAC_OPER_DATA); else pass_cnt++;
    chk_cnt++; if (MAC_OUT_SEL !== 6'd0) $display("FAIL rstmid_sel act=%0h exp=0", MAC_OUT_SEL); else pass_cnt++;
    #2;
    rst_n = 1'b1;
    tick;
    start_job(8'd2, 1'b0, 1'b0, 1'b0, 6'h09);
    tick;
    send(32'd2, 32'd5);
    send(32'd4, 32'd1);
    OPER_VALID = 1'b0;
    tick;
    tick;
    chk_cnt++; if (RES_VALID !== 1'b1) $display("FAIL rstmid_next_valid act=%b exp=1", RES_VALID); else pass_cnt++;
    chk_cnt++; if (RES_DATA !== 32'd14) $display("FAIL rstmid_next_data act=%0d exp=14", RES_DATA); else pass_cnt++;
    chk_cnt++; if (MAC_OUT_SEL !== 6'h09) $display("FAIL rstmid_next_sel act=%0h exp=09", MAC_OUT_SEL); else pass_cnt++;
    pop_result;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_bubbles;
    test_zero_taps;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
